// File: rtl/latch_arb_pkg.sv
// Shared types and sizing helpers for the gated-latch write arbiter.
package latch_arb_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StOpen  = 2'd2,
    StHold  = 2'd3
  } state_e;

  // Width of the phase down-counter: must hold the longest phase length.
  function automatic int unsigned cnt_width(input int unsigned setup_cyc,
                                            input int unsigned open_cyc,
                                            input int unsigned hold_cyc);
    int unsigned m;
    m = setup_cyc;
    if (open_cyc > m) m = open_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first masked request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IdW-1:0]   rr_ptr,
  output logic             valid,
  output logic [IdW-1:0]   winner
);

  logic [N_REQ-1:0] req_m;
  logic [IdW-1:0]   idx;

  assign req_m = req & mask;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = IdW'((32'(rr_ptr) + i) % N_REQ);
      if (!valid && req_m[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sequencing setup/open/hold writes into one shared D latch.
// Define LATCH_ARB_READBACK_EN to add the latch_q readback check and wr_err output.
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      wdata,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [DW-1:0]            latch_d,
  output logic                     latch_en
`ifdef LATCH_ARB_READBACK_EN
  ,
  input  logic [DW-1:0]            latch_q,
  output logic                     wr_err
`endif
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] OpenLd  = CntW'(OPEN_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [DW-1:0]    d_q, d_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             last;
  logic             arb_valid;
  logic [IdW-1:0]   arb_winner;

  // The requester just acked may still show req for a cycle; keep it out of this pick.
  rr_arbiter #(
    .N_REQ (N_REQ),
    .IdW   (IdW)
  ) u_rr_arbiter (
    .req    (req),
    .mask   (~ack_q),
    .rr_ptr (rr_ptr_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign last = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    d_d      = d_q;
    busy_d   = busy_q;
    ack_d    = '0;
    en_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          grant_d = arb_winner;
          d_d     = wdata[arb_winner*DW +: DW];
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        if (last) begin
          state_d = StOpen;
          cnt_d   = OpenLd;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StOpen: begin
        if (last) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
          en_d  = 1'b1;
        end
      end
      StHold: begin
        if (last) begin
          state_d  = StIdle;
          ack_d    = N_REQ'(1) << grant_q;
          busy_d   = 1'b0;
          rr_ptr_d = (grant_q == IdW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      d_q      <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      d_q      <= d_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign latch_d  = d_q;
  assign latch_en = en_q;

`ifdef LATCH_ARB_READBACK_EN
  logic err_q, err_d;

  // Sample the latch on the final hold cycle so the error lines up with ack.
  always_comb begin
    err_d = 1'b0;
    if (state_q == StHold && last) err_d = (latch_q != d_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign wr_err = err_q;
`endif

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_latch_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int S  = 1;
  localparam int O  = 2;
  localparam int H  = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic [DW-1:0]   latch_d;
  logic            latch_en;
  logic [DW-1:0]   lstore;
`ifdef LATCH_ARB_READBACK_EN
  logic [DW-1:0]   latch_q;
  logic            wr_err;
  logic [DW-1:0]   stuck;
  assign latch_q = lstore | stuck;
`endif

  int checks;
  int failures;
  logic last_err;

  always #5 clk = ~clk;

  latch_write_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wdata    (wdata),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .latch_d  (latch_d),
    .latch_en (latch_en)
`ifdef LATCH_ARB_READBACK_EN
    ,
    .latch_q  (latch_q),
    .wr_err   (wr_err)
`endif
  );

  // Behavioural gated D latch driven by the DUT.
  always @(latch_en or latch_d) if (latch_en) lstore = latch_d;

  // Reference model: a write occupies S+O+H cycles after its grant edge; gate open for
  // cycles S..S+O-1; ack on the last edge; the acked requester is ignored for one cycle.
  int            m_ptr, m_gid, m_k;
  logic          m_busy, m_en, m_err;
  logic [N-1:0]  m_ack;
  logic [DW-1:0] m_d;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_gid <= 0; m_k <= 0; m_busy <= 1'b0; m_en <= 1'b0;
      m_ack <= '0; m_d <= '0; m_err <= 1'b0;
    end else begin
      m_ack <= '0;
      m_err <= 1'b0;
      if (m_busy) begin
        m_k  <= m_k + 1;
        m_en <= (m_k + 1 >= S) && (m_k + 1 < S + O);
        if (m_k + 1 == S + O + H) begin
          m_busy <= 1'b0;
          m_ack  <= N'(1 << m_gid);
          m_ptr  <= (m_gid + 1) % N;
`ifdef LATCH_ARB_READBACK_EN
          m_err  <= (latch_q != m_d);
`endif
        end
      end else if (pick(req & ~m_ack, m_ptr) >= 0) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_gid  <= pick(req & ~m_ack, m_ptr);
        m_d    <= wdata[pick(req & ~m_ack, m_ptr)*DW +: DW];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    check("busy", busy, m_busy);
    check("latch_en", latch_en, m_en);
    check("ack", ack, m_ack);
    check("ack_onehot0", $onehot0(ack), 1);
    check("latch_d", latch_d, m_d);
    check("grant_id", grant_id, m_gid[1:0]);
`ifdef LATCH_ARB_READBACK_EN
    check("wr_err", wr_err, m_err);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // mode 0: drop req at ack; 1: drop one cycle late; 2: keep req held.
  task automatic run_until_ack(input int mode, output int gid);
    int en_cnt;
    bit got;
    en_cnt = 0;
    got    = 1'b0;
    gid    = -1;
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      if (latch_en) en_cnt++;
      if (ack != '0) begin
        got = 1'b1;
        for (int i = 0; i < N; i++) if (ack[i]) gid = i;
`ifdef LATCH_ARB_READBACK_EN
        last_err = wr_err;
`endif
      end
    end
    check("ack_seen", got, 1);
    if (got) begin
      check("open_cycles", en_cnt, O);
      check("latch_holds_d", lstore, m_d);
      if (mode == 0) req[gid] = 1'b0;
      if (mode == 1) begin
        tick();
        req[gid] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) if (!req[i]) wdata[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    int g;
    int ord[4];
    bit seen;
    logic [N-1:0] nw;
    checks   = 0;
    failures = 0;
    last_err = 1'b0;
    ord      = '{0, 1, 3, 0};
    wdata    = {$urandom, $urandom};
`ifdef LATCH_ARB_READBACK_EN
    stuck = '0;
`endif
    rst_n = 1'b0;
    req   = '1;

    // Reset holds everything quiet even with all requests raised.
    repeat (3) begin
      tick();
      check("rst_latch_en", latch_en, 0);
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_latch_d", latch_d, 0);
    end
    req   = '0;
    rst_n = 1'b1;

    // Single write from requester 2.
    req = 4'b0100;
    wdata[2*DW +: DW] = 8'hA5;
    run_until_ack(0, g);
    check("single_gid", g, 2);
    check("single_latch", lstore, 8'hA5);

    // Contention from pointer 0 with requests held.
    reset_pulse();
    req = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      run_until_ack(2, g);
      check("rr_order", g, ord[j]);
    end
    req = '0;

    // Late drop: requester 1 must not be served twice.
    req = 4'b0010;
    run_until_ack(1, g);
    check("late_gid", g, 1);
    repeat (3) begin
      tick();
      check("late_no_regrant", busy, 0);
    end
    req[3] = 1'b1;
    run_until_ack(0, g);
    check("late_next", g, 3);

    // Reset with the gate open; pointer must restart at 0.
    req = 4'b0010;
    run_until_ack(0, g);
    check("pre_reset_gid", g, 1);
    req  = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = busy;
    end
    check("pre_reset_busy", seen, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("gate_open_e2", latch_en, 1);
    rst_n = 1'b0;
    #1;
    check("async_latch_en", latch_en, 0);
    check("async_busy", busy, 0);
    check("async_ack", ack, 0);
    req = 4'b1001;
    tick();
    rst_n = 1'b1;
    run_until_ack(0, g);
    check("restart_gid", g, 0);
    run_until_ack(0, g);
    check("restart_next", g, 3);
    req = '0;

    // Random traffic.
    for (int it = 0; it < 24; it++) begin
      nw = N'($urandom) & ~req;
      if ((req | nw) == '0) nw[$urandom_range(0, N-1)] = 1'b1;
      for (int i = 0; i < N; i++) if (nw[i]) wdata[i*DW +: DW] = DW'($urandom);
      req = req | nw;
      run_until_ack($urandom_range(0, 1), g);
    end
    req = '0;
    for (int c = 0; c < 20 && busy; c++) tick();
    if (busy) run_until_ack(0, g);
    tick();
    check("drained", busy, 0);

`ifdef LATCH_ARB_READBACK_EN
    // Readback against a latch with bit 4 stuck high, then a healthy latch.
    stuck = 8'h10;
    req = 4'b0001;
    wdata[0 +: DW] = 8'h0F;
    run_until_ack(0, g);
    check("rb_err_stuck", last_err, 1);
    stuck = 8'h00;
    req = 4'b0001;
    wdata[0 +: DW] = 8'h0F;
    run_until_ack(0, g);
    check("rb_err_clean", last_err, 0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
